// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared elevator types, floor width helper and scheduler defaults
package elevator_pkg;

    localparam int NUM_FLOORS_DEF   = 4;
    localparam int DWELL_CYCLES_DEF = 3;

    function automatic int floor_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FLOOR_W = floor_w(NUM_FLOORS_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/elevator_req_scheduler_if.sv
// rtl/elevator_req_scheduler_if.sv - call/target bus between buttons, controller and scheduler (SCHED_SERVED_CNT_EN adds served_cnt)
interface elevator_req_scheduler_if
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF
);
    localparam int FW = floor_w(NUM_FLOORS);

    logic [NUM_FLOORS-1:0] call_btn;
    logic [FW-1:0]         current_floor;
    logic                  door_open;
    logic [FW-1:0]         req_floor;
    logic                  req_valid;
    logic [NUM_FLOORS-1:0] pending;
`ifdef SCHED_SERVED_CNT_EN
    logic [15:0]           served_cnt;

    modport master (
        output call_btn, current_floor, door_open,
        input  req_floor, req_valid, pending, served_cnt
    );
    modport slave (
        input  call_btn, current_floor, door_open,
        output req_floor, req_valid, pending, served_cnt
    );
`else
    modport master (
        output call_btn, current_floor, door_open,
        input  req_floor, req_valid, pending
    );
    modport slave (
        input  call_btn, current_floor, door_open,
        output req_floor, req_valid, pending
    );
`endif

endinterface

// File: rtl/elevator_floor_pick.sv
// rtl/elevator_floor_pick.sv - nearest pending floor above/below the car, and pending-here flag
module elevator_floor_pick
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FW         = floor_w(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FW-1:0]         current_floor,
    output logic [FW-1:0]         nearest_up,
    output logic [FW-1:0]         nearest_down,
    output logic                  any_up,
    output logic                  any_down,
    output logic                  here
);

    logic in_range;
    assign in_range = int'(current_floor) < NUM_FLOORS;

    always_comb begin
        nearest_up   = '0;
        nearest_down = '0;
        any_up       = 1'b0;
        any_down     = 1'b0;
        here         = 1'b0;
        if (in_range) begin
            here = pending[current_floor];
            // Scan toward the car so the last hit is the closest floor.
            for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
                if (pending[i] && (i > int'(current_floor))) begin
                    nearest_up = FW'(i);
                    any_up     = 1'b1;
                end
            end
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (pending[i] && (i < int'(current_floor))) begin
                    nearest_down = FW'(i);
                    any_down     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/elevator_req_scheduler.sv
// rtl/elevator_req_scheduler.sv - SCAN request scheduler: pending mask, dwell retire, direction FSM (SCHED_SERVED_CNT_EN adds served_cnt)
module elevator_req_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
    parameter int DWELL_CYCLES = DWELL_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    elevator_req_scheduler_if.slave bus
);

    localparam int FW = floor_w(NUM_FLOORS);
    localparam int CW = $clog2(DWELL_CYCLES + 1);

    sched_state_t          state, state_next;
    logic [NUM_FLOORS-1:0] pending_q;
    logic [CW-1:0]         dwell_cnt, dwell_base, dwell_next;
    logic [FW-1:0]         last_floor;
    logic [FW-1:0]         req_floor_q, floor_next;
    logic                  req_valid_q, valid_next;

    logic [FW-1:0]         cur_floor;
    logic [FW-1:0]         nearest_up, nearest_down;
    logic                  any_up, any_down, here, in_range;
    logic                  dwell_hit, retire;
    logic [NUM_FLOORS-1:0] retire_mask;

    assign cur_floor = bus.current_floor;
    assign in_range  = int'(cur_floor) < NUM_FLOORS;

    elevator_floor_pick #(
        .NUM_FLOORS (NUM_FLOORS),
        .FW         (FW)
    ) u_pick (
        .pending       (pending_q),
        .current_floor (cur_floor),
        .nearest_up    (nearest_up),
        .nearest_down  (nearest_down),
        .any_up        (any_up),
        .any_down      (any_down),
        .here          (here)
    );

    // A floor change restarts the count, but that cycle's open door still counts as the first.
    assign dwell_base  = (cur_floor != last_floor) ? '0 : dwell_cnt;
    assign dwell_hit   = bus.door_open && here;
    assign retire      = dwell_hit && (dwell_base == CW'(DWELL_CYCLES - 1));
    assign retire_mask = retire ? (NUM_FLOORS'(1) << cur_floor) : '0;
    assign dwell_next  = (!dwell_hit || retire) ? '0 : dwell_base + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            dwell_cnt  <= '0;
            last_floor <= '0;
        end else begin
            pending_q  <= (pending_q | bus.call_btn) & ~retire_mask;
            dwell_cnt  <= dwell_next;
            last_floor <= cur_floor;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_floor_q <= '0;
            req_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            req_floor_q <= floor_next;
            req_valid_q <= valid_next;
        end
    end

    always_comb begin
        state_next = state;
        floor_next = cur_floor;
        valid_next = 1'b0;
        if (!in_range) begin
            state_next = IDLE;
            floor_next = req_floor_q;
        end else if (pending_q == '0) begin
            state_next = IDLE;
        end else begin
            valid_next = 1'b1;
            // A call at the car's own floor is served first and freezes direction until it retires.
            if (!here) begin
                unique case (state)
                    DOWN: begin
                        if (any_down) begin
                            state_next = DOWN;
                            floor_next = nearest_down;
                        end else begin
                            state_next = UP;
                            floor_next = nearest_up;
                        end
                    end
                    default: begin
                        if (any_up) begin
                            state_next = UP;
                            floor_next = nearest_up;
                        end else begin
                            state_next = DOWN;
                            floor_next = nearest_down;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.pending   = pending_q;
    assign bus.req_floor = req_floor_q;
    assign bus.req_valid = req_valid_q;

`ifdef SCHED_SERVED_CNT_EN
    logic [15:0] served_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            served_cnt_q <= '0;
        end else if (retire && (served_cnt_q != 16'hFFFF)) begin
            served_cnt_q <= served_cnt_q + 16'd1;
        end
    end

    assign bus.served_cnt = served_cnt_q;
`endif

endmodule

// File: tb/tb_elevator_req_scheduler.sv
// tb/tb_elevator_req_scheduler.sv - directed bench for elevator_req_scheduler (SCHED_SERVED_CNT_EN enables served_cnt checks)
module tb_elevator_req_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    elevator_req_scheduler_if #(.NUM_FLOORS(4)) bus ();

    elevator_req_scheduler #(
        .NUM_FLOORS   (4),
        .DWELL_CYCLES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.call_btn      = '0;
        bus.door_open     = 1'b0;
        bus.current_floor = '0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        bus.call_btn      = '0;
        bus.door_open     = 1'b0;
        bus.current_floor = '0;
        tick(2);
        rst = 1'b0;
        tick();
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_valid", 32'(bus.req_valid), 0);
        chk("rst_floor", 32'(bus.req_floor), 0);

        // 1: async reset with calls pending
        bus.call_btn = 4'b1010;
        tick();
        bus.call_btn = 4'b0000;
        tick();
        chk("s1_pending", 32'(bus.pending), 32'hA);
        chk("s1_floor_pre", 32'(bus.req_floor), 1);
        chk("s1_state_pre", 32'(dut.state), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("s1_pending_rst", 32'(bus.pending), 0);
        chk("s1_valid_rst", 32'(bus.req_valid), 0);
        chk("s1_floor_rst", 32'(bus.req_floor), 0);
        chk("s1_state_rst", 32'(dut.state), 0);
        rst = 1'b0;
        tick();

        // 2: single pulse to floor 3, then dwell retire
        do_reset();
        bus.call_btn = 4'b1000;
        tick();
        bus.call_btn = 4'b0000;
        chk("s2_pending", 32'(bus.pending), 32'h8);
        chk("s2_valid_n1", 32'(bus.req_valid), 0);
        tick();
        chk("s2_floor", 32'(bus.req_floor), 3);
        chk("s2_valid", 32'(bus.req_valid), 1);
        bus.current_floor = 2'd3;
        bus.door_open     = 1'b1;
        tick(2);
        chk("s2_pending_mid", 32'(bus.pending), 32'h8);
        tick();
        chk("s2_pending_ret", 32'(bus.pending), 0);
        bus.door_open = 1'b0;
        tick();
        chk("s2_valid_done", 32'(bus.req_valid), 0);
        chk("s2_park", 32'(bus.req_floor), 3);
        chk("s2_state_idle", 32'(dut.state), 0);

        // 3: keep direction up, then reverse once exhausted
        do_reset();
        bus.current_floor = 2'd1;
        bus.call_btn = 4'b1000;
        tick();
        bus.call_btn = 4'b0001;
        tick();
        bus.call_btn = 4'b0000;
        tick();
        chk("s3_floor_up", 32'(bus.req_floor), 3);
        chk("s3_state_up", 32'(dut.state), 1);
        bus.current_floor = 2'd3;
        bus.door_open     = 1'b1;
        tick(3);
        chk("s3_pending", 32'(bus.pending), 32'h1);
        bus.door_open = 1'b0;
        tick();
        chk("s3_state_dn", 32'(dut.state), 2);
        chk("s3_floor_dn", 32'(bus.req_floor), 0);
        chk("s3_valid", 32'(bus.req_valid), 1);

        // 4: idle at 2 with calls above and below, up wins
        do_reset();
        bus.current_floor = 2'd2;
        bus.call_btn = 4'b1011;
        tick();
        bus.call_btn = 4'b0000;
        tick();
        chk("s4_floor", 32'(bus.req_floor), 3);
        chk("s4_state", 32'(dut.state), 1);

        // 5: interrupted dwell, then retire with a same-floor press
        do_reset();
        bus.current_floor = 2'd1;
        bus.call_btn = 4'b0010;
        tick();
        bus.call_btn  = 4'b0000;
        bus.door_open = 1'b1;
        tick(2);
        chk("s5_no_retire", 32'(bus.pending), 32'h2);
        bus.door_open = 1'b0;
        tick();
        chk("s5_cnt_clear", 32'(dut.dwell_cnt), 0);
        chk("s5_still_pend", 32'(bus.pending), 32'h2);
        bus.door_open = 1'b1;
        tick(2);
        chk("s5_pend_mid", 32'(bus.pending), 32'h2);
        bus.call_btn = 4'b0010;
        tick();
        bus.call_btn  = 4'b0000;
        bus.door_open = 1'b0;
        chk("s5_absorbed", 32'(bus.pending), 0);
        tick();
        chk("s5_valid", 32'(bus.req_valid), 0);

`ifdef SCHED_SERVED_CNT_EN
        // 6: five retires counted
        do_reset();
        chk("s6_cnt0", 32'(bus.served_cnt), 0);
        for (int i = 0; i < 5; i++) begin
            bus.current_floor = 2'(i % 4);
            bus.call_btn      = 4'(1 << (i % 4));
            tick();
            bus.call_btn  = 4'b0000;
            bus.door_open = 1'b1;
            tick(3);
            bus.door_open = 1'b0;
            tick();
        end
        chk("s6_cnt5", 32'(bus.served_cnt), 5);
        chk("s6_pending", 32'(bus.pending), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
